scanner_host_seq: RTL and testbench

SCANNER_HOST_SEQ -- requirements
Module: scanner_host_seq

---
 rtl/scanner_pkg.sv | 47 ++++
 rtl/scanner_watchdog.sv | 32 +++
 rtl/scanner_host_seq.sv | 193 +++++++++++++++++++
 tb/tb_scanner_host_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// scanner_pkg: scanner process codes, host FSM states, error codes
// and the legal-step helper shared by the scanner host sequencer.
package scanner_pkg;

    typedef enum logic [3:0] {
        PC_IDLE      = 4'd0,
        PC_ENV_CHECK = 4'd1,
        PC_LOAD_RET  = 4'd2,
        PC_LOAD_WFR  = 4'd3,
        PC_SETUP     = 4'd4,
        PC_ALIGN     = 4'd5,
        PC_EXPOSE    = 4'd6,
        PC_UNLOAD    = 4'd7,
        PC_ERROR     = 4'd15
    } proc_code_t;

    typedef enum logic [2:0] {
        ERR_OK    = 3'b000,
        ERR_SCAN  = 3'b001,
        ERR_TMO   = 3'b010,
        ERR_ABORT = 3'b011,
        ERR_SEQ   = 3'b100
    } err_code_t;

    typedef enum logic [2:0] {
        H_IDLE,
        H_ARM,
        H_START,
        H_WAIT_LEAVE,
        H_RUN,
        H_FAULT,
        H_DONE
    } host_state_t;

    // A scanner step is legal if it advances by one inside 1..7,
    // wraps UNLOAD back to IDLE, or reports ERROR.
    function automatic logic step_legal(
        input logic [3:0] prev,
        input logic [3:0] cur
    );
        step_legal = (cur == PC_ERROR)
            || (prev == PC_UNLOAD && cur == PC_IDLE)
            || (prev >= PC_ENV_CHECK && prev <= PC_EXPOSE
                && cur == prev + 4'd1);
    endfunction

endpackage

// File: rtl/scanner_watchdog.sv
// scanner_watchdog: per-step cycle counter; expired flags the
// cycle in which the count would reach TIMEOUT.
module scanner_watchdog
    import scanner_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] count;

    // Count enabled cycles since the last clear, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != W'(TIMEOUT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && !clear && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/scanner_host_seq.sv
// scanner_host_seq: host-side job sequencer for the wafer scanner.
// Define SCANNER_SEQ_CHECK_EN to fault on illegal scanner steps.
module scanner_host_seq
    import scanner_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ILK_LEN = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [7:0] job_wafers,
    input  logic       abort,
    input  logic [3:0] current_process,
    input  logic       source_status,
    input  logic       env_status,
    output logic       op_start_btn,
    output logic       interlock_sig,
    output logic       busy,
    output logic       done,
    output logic [2:0] err_code,
    output logic [7:0] wafer_cnt
);

    localparam int IW = (ILK_LEN > 1) ? $clog2(ILK_LEN) : 1;
    localparam logic [IW-1:0] ILK_LAST = IW'(ILK_LEN - 1);

    host_state_t   state;
    logic [3:0]    prev_proc;
    logic [7:0]    wafers_lat;
    logic [IW-1:0] ilk_cnt;
    logic          entered;
    logic          proc_chg;
    logic          active;
    logic          wd_en;
    logic          wd_clr;
    logic          wd_exp;
    logic          seq_bad;
    logic          unload_done;
    logic          fault_hit;
    logic [2:0]    fault_code;

    assign proc_chg = current_process != prev_proc;
    assign active   = state inside {H_ARM, H_START, H_WAIT_LEAVE, H_RUN};
    assign wd_en    = state inside {H_ARM, H_WAIT_LEAVE, H_RUN};
    assign wd_clr   = entered || proc_chg;

    assign unload_done = (state == H_RUN)
        && (prev_proc == PC_UNLOAD)
        && (current_process == PC_IDLE);

`ifdef SCANNER_SEQ_CHECK_EN
    assign seq_bad = (state == H_RUN) && proc_chg
        && !step_legal(prev_proc, current_process);
`else
    assign seq_bad = 1'b0;
`endif

    scanner_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clr),
        .enable  (wd_en),
        .expired (wd_exp)
    );

    // Remember last cycle's process code to detect scanner steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_proc <= PC_IDLE;
        end else begin
            prev_proc <= current_process;
        end
    end

    // Pick the highest-priority fault among the active-state events.
    always_comb begin
        fault_hit  = active;
        fault_code = ERR_OK;
        if (abort) begin
            fault_code = ERR_ABORT;
        end else if (current_process == PC_ERROR) begin
            fault_code = ERR_SCAN;
        end else if (seq_bad) begin
            fault_code = ERR_SEQ;
        end else if (wd_exp) begin
            fault_code = ERR_TMO;
        end else begin
            fault_hit = 1'b0;
        end
    end

    // Host FSM; every output is set together with the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= H_IDLE;
            job_ready     <= 1'b0;
            busy          <= 1'b0;
            op_start_btn  <= 1'b0;
            interlock_sig <= 1'b0;
            done          <= 1'b0;
            err_code      <= ERR_OK;
            wafer_cnt     <= 8'd0;
            wafers_lat    <= 8'd0;
            ilk_cnt       <= '0;
            entered       <= 1'b0;
        end else begin
            op_start_btn <= 1'b0;
            done         <= 1'b0;
            entered      <= 1'b0;
            if (fault_hit) begin
                state         <= H_FAULT;
                entered       <= 1'b1;
                ilk_cnt       <= '0;
                err_code      <= fault_code;
                interlock_sig <= (fault_code != ERR_SCAN);
            end else begin
                unique case (state)
                    H_IDLE: begin
                        job_ready <= 1'b1;
                        if (job_valid && job_ready) begin
                            wafers_lat <= job_wafers;
                            wafer_cnt  <= 8'd0;
                            err_code   <= ERR_OK;
                            job_ready  <= 1'b0;
                            busy       <= 1'b1;
                            entered    <= 1'b1;
                            if (job_wafers == 8'd0) begin
                                state <= H_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= H_ARM;
                            end
                        end
                    end
                    H_ARM: begin
                        if (source_status && env_status
                            && current_process == PC_IDLE) begin
                            state        <= H_START;
                            op_start_btn <= 1'b1;
                            entered      <= 1'b1;
                        end
                    end
                    H_START: begin
                        state   <= H_WAIT_LEAVE;
                        entered <= 1'b1;
                    end
                    H_WAIT_LEAVE: begin
                        if (current_process != PC_IDLE) begin
                            state   <= H_RUN;
                            entered <= 1'b1;
                        end
                    end
                    H_RUN: begin
                        if (unload_done) begin
                            wafer_cnt <= wafer_cnt + 8'd1;
                            entered   <= 1'b1;
                            if (wafer_cnt + 8'd1 == wafers_lat) begin
                                state <= H_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= H_ARM;
                            end
                        end
                    end
                    H_FAULT: begin
                        if (ilk_cnt == ILK_LAST) begin
                            interlock_sig <= 1'b0;
                            state         <= H_DONE;
                            done          <= 1'b1;
                            entered       <= 1'b1;
                        end else begin
                            ilk_cnt <= ilk_cnt + IW'(1);
                        end
                    end
                    H_DONE: begin
                        state     <= H_IDLE;
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                        entered   <= 1'b1;
                    end
                    default: begin
                        state <= H_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scanner_host_seq.sv
// tb_scanner_host_seq: randomized jobs against a job-level outcome
// model, plus directed reset, zero-wafer and fault scenarios.
module tb_scanner_host_seq;

    localparam int TMO    = 20;
    localparam int ILK    = 2;
    localparam int BUDGET = 1500;

    localparam int K_NONE  = 0;
    localparam int K_ERR   = 1;
    localparam int K_STUCK = 2;
    localparam int K_ABORT = 3;
    localparam int K_SEQ   = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_wafers;
    logic       abort;
    logic [3:0] current_process;
    logic       source_status;
    logic       env_status;
    logic       op_start_btn;
    logic       interlock_sig;
    logic       busy;
    logic       done;
    logic [2:0] err_code;
    logic [7:0] wafer_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scanner_host_seq #(
        .TIMEOUT (TMO),
        .ILK_LEN (ILK)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_wafers      (job_wafers),
        .abort           (abort),
        .current_process (current_process),
        .source_status   (source_status),
        .env_status      (env_status),
        .op_start_btn    (op_start_btn),
        .interlock_sig   (interlock_sig),
        .busy            (busy),
        .done            (done),
        .err_code        (err_code),
        .wafer_cnt       (wafer_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, job_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, op_start_btn, 0);
        chk({tag, "_ilk"}, interlock_sig, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_code, 0);
        chk({tag, "_cnt"}, wafer_cnt, 0);
    endtask

    // One job: drive an accept, play the scanner, compare the outcome.
    task automatic run_job(input int w, input int kind, input int fw,
                           input int fs, input int period,
                           input int env_lo);
        int exp_cnt, exp_err, exp_st, exp_ilk;
        int starts, ilk_cyc, first_start, ilk_rise, stuck_e;
        int done_e, d_err, d_cnt, extra;
        int step, timer, sc_w, nxt;
        bit act, frozen, got_done;

        unique case (kind)
            K_ERR:   begin exp_cnt = fw; exp_err = 1; exp_st = fw + 1; exp_ilk = 0;   end
            K_STUCK: begin exp_cnt = fw; exp_err = 2; exp_st = fw + 1; exp_ilk = ILK; end
            K_ABORT: begin exp_cnt = fw; exp_err = 3; exp_st = fw + 1; exp_ilk = ILK; end
`ifdef SCANNER_SEQ_CHECK_EN
            K_SEQ:   begin exp_cnt = fw; exp_err = 4; exp_st = fw + 1; exp_ilk = ILK; end
`else
            K_SEQ:   begin exp_cnt = w;  exp_err = 0; exp_st = w;      exp_ilk = 0;   end
`endif
            default: begin exp_cnt = w;  exp_err = 0; exp_st = w;      exp_ilk = 0;   end
        endcase

        starts = 0; ilk_cyc = 0; first_start = -1; ilk_rise = -1;
        stuck_e = -1; done_e = -1; d_err = 0; d_cnt = 0;
        step = 0; timer = 0; sc_w = 0; act = 0; frozen = 0;
        got_done = 0;

        @(negedge clk);
        chk("pre_ready", job_ready, 1);
        job_valid  = 1'b1;
        job_wafers = 8'(w);
        env_status = (env_lo == 0);
        @(negedge clk);
        job_valid = 1'b0;

        for (int e = 0; e < BUDGET && !got_done; e++) begin
            if (e > 0) @(negedge clk);
            chk("excl", op_start_btn & interlock_sig, 0);
            chk("busy_ready", busy, !job_ready);
            if (op_start_btn) begin
                starts++;
                if (first_start < 0) first_start = e;
            end
            if (interlock_sig) begin
                ilk_cyc++;
                if (ilk_rise < 0) ilk_rise = e;
            end
            if (done) begin
                got_done = 1;
                done_e = e;
                d_err = int'(err_code);
                d_cnt = int'(wafer_cnt);
            end
            env_status = (e >= env_lo);
            abort = 1'b0;
            if (op_start_btn && !act && !frozen) begin
                act = 1; step = 1; timer = 0;
                current_process = 4'd1;
            end else if (act && !frozen) begin
                timer++;
                if (timer >= period) begin
                    timer = 0;
                    nxt = (step == 7) ? 0 : step + 1;
                    if (kind == K_SEQ && sc_w == fw && step == 4) nxt = 6;
                    if (kind == K_ERR && sc_w == fw && nxt == fs) begin
                        current_process = 4'd15;
                        frozen = 1;
                    end else begin
                        if (kind == K_ABORT && sc_w == fw && step == 7)
                            abort = 1'b1;
                        current_process = 4'(nxt);
                        step = nxt;
                        if (kind == K_STUCK && sc_w == fw && nxt == fs) begin
                            frozen = 1;
                            stuck_e = e;
                        end
                        if (nxt == 0) begin
                            act = 0;
                            sc_w++;
                        end
                    end
                end
            end
        end

        if (!got_done) begin
            chk("done_seen", 0, 1);
        end else begin
            chk("err", d_err, exp_err);
            chk("cnt", d_cnt, exp_cnt);
            chk("starts", starts, exp_st);
            chk("ilk_len", ilk_cyc, exp_ilk);
            if (w == 0) chk("zero_done_lat", done_e, 0);
            else        chk("start_lat", first_start, env_lo + 1);
            if (kind == K_STUCK) chk("tmo_at", ilk_rise, stuck_e + 1 + TMO);
        end

        abort = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("extra_done", extra, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", job_ready, 1);
        chk("sticky_err", err_code, exp_err);
        current_process = 4'd0;
        env_status = 1'b1;
    endtask

    initial begin
        int nd, w, kind, fw;
        reset_n = 1'b0;
        job_valid = 1'b0;
        job_wafers = 8'd0;
        abort = 1'b0;
        current_process = 4'd0;
        source_status = 1'b1;
        env_status = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        chk("ready_pre", job_ready, 0);
        @(negedge clk);
        chk("ready_rise", job_ready, 1);

        run_job(2, K_NONE, 0, 2, 10, 0);
        run_job(1, K_ERR, 0, 6, 10, 0);
        run_job(1, K_STUCK, 0, 5, 10, 0);
        run_job(2, K_ABORT, 1, 2, 6, 0);
        run_job(1, K_NONE, 0, 2, 4, 5);
        run_job(0, K_NONE, 0, 2, 4, 0);
        run_job(1, K_SEQ, 0, 2, 5, 0);

        @(negedge clk);
        job_valid = 1'b1;
        job_wafers = 8'd3;
        @(negedge clk);
        job_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        @(negedge clk);
        reset_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_nodone", nd, 0);
        chk("mid_ready", job_ready, 1);

        for (int j = 0; j < 40; j++) begin
            w = $urandom_range(0, 3);
            kind = (w == 0) ? K_NONE : $urandom_range(0, 4);
            fw = (w == 0) ? 0 : $urandom_range(0, w - 1);
            run_job(w, kind, fw, $urandom_range(2, 7),
                    $urandom_range(2, 12), $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
